// File: rtl/casez_dispatch_pkg.sv
// Shared types and fixed wildcard patterns for the casez dispatcher.
// A value hits a pattern when (value & MSK) == (VAL & MSK); a cleared mask bit is don't-care.
package casez_dispatch_pkg;

    typedef enum logic [1:0] {CLS_P0, CLS_P1, CLS_P2, CLS_DEF} cls_e;
    typedef enum logic [1:0] {IDLE, PRE, POST, DEF} state_e;

    localparam logic [3:0] P0_VAL  = 4'b0000;
    localparam logic [3:0] P0_MSK  = 4'b1111;
    localparam logic [3:0] P0_CODE = 4'b0000;
    localparam logic [3:0] P1_VAL  = 4'b0001;
    localparam logic [3:0] P1_MSK  = 4'b1101;
    localparam logic [3:0] P1_CODE = 4'b0001;
    localparam logic [3:0] P2_VAL  = 4'b0100;
    localparam logic [3:0] P2_MSK  = 4'b1111;
    localparam logic [3:0] P2_CODE = 4'b0010;

    function automatic logic [3:0] cls_code(input cls_e c);
        case (c)
            CLS_P0:  cls_code = P0_CODE;
            CLS_P1:  cls_code = P1_CODE;
            CLS_P2:  cls_code = P2_CODE;
            default: cls_code = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/casez_dispatch_match.sv
// Combinational first-hit-wins matcher: value in, class out.
module pattern_match
    import casez_dispatch_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] value,
    output cls_e         cls
);

    localparam logic [W-1:0] M0 = W'(P0_MSK);
    localparam logic [W-1:0] V0 = W'(P0_VAL & P0_MSK);
    localparam logic [W-1:0] M1 = W'(P1_MSK);
    localparam logic [W-1:0] V1 = W'(P1_VAL & P1_MSK);
    localparam logic [W-1:0] M2 = W'(P2_MSK);
    localparam logic [W-1:0] V2 = W'(P2_VAL & P2_MSK);

    always_comb begin
        cls = CLS_DEF;
        if ((value & M0) == V0)      cls = CLS_P0;
        else if ((value & M1) == V1) cls = CLS_P1;
        else if ((value & M2) == V2) cls = CLS_P2;
    end

endmodule

// File: rtl/casez_dispatch.sv
// Wildcard-priority dispatcher: accept a value in IDLE, settle, publish a code, hold.
// One shared down-counter times PRE, POST and DEF phases.
module casez_dispatch
    import casez_dispatch_pkg::*;
#(
    parameter int W        = 4,
    parameter int PRE_CYC  = 3,
    parameter int POST_CYC = 3,
    parameter int DEF_CYC  = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_value,
    output logic             out_valid,
    output logic [1:0]       out_class,
    output logic [W-1:0]     out_code,
    output logic             busy,
    input  logic             clr_cnt,
    output logic [4*CNT_W-1:0] hit_cnt
);

    localparam int MAXC = (PRE_CYC > POST_CYC) ? ((PRE_CYC > DEF_CYC) ? PRE_CYC : DEF_CYC)
                                               : ((POST_CYC > DEF_CYC) ? POST_CYC : DEF_CYC);
    localparam int CW = (MAXC < 2) ? 1 : $clog2(MAXC);
    localparam logic [CW-1:0] PRE_LD  = CW'(PRE_CYC - 1);
    localparam logic [CW-1:0] POST_LD = CW'((POST_CYC > 0) ? POST_CYC - 1 : 0);
    localparam logic [CW-1:0] DEF_LD  = CW'(DEF_CYC - 1);

    state_e                  state, state_d;
    logic [CW-1:0]           cnt, cnt_d;
    cls_e                    cls_q, cls_in;
    logic                    accept, pub;
    logic [3:0][CNT_W-1:0]   hits;

    pattern_match #(.W(W)) u_match (.value(in_value), .cls(cls_in));

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid & in_ready;
    assign hit_cnt  = hits;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pub     = 1'b0;
        case (state)
            IDLE: if (accept) begin
                state_d = (cls_in == CLS_DEF) ? DEF : PRE;
                cnt_d   = (cls_in == CLS_DEF) ? DEF_LD : PRE_LD;
            end
            PRE: if (cnt == '0) begin
                pub = 1'b1;
                if (POST_CYC == 0) state_d = IDLE;
                else begin
                    state_d = POST;
                    cnt_d   = POST_LD;
                end
            end else cnt_d = cnt - CW'(1);
            POST: if (cnt == '0) state_d = IDLE;
                  else cnt_d = cnt - CW'(1);
            DEF: if (cnt == '0) begin
                pub     = 1'b1;
                state_d = IDLE;
            end else cnt_d = cnt - CW'(1);
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cls_q     <= CLS_P0;
            out_valid <= 1'b0;
            out_class <= 2'd0;
            out_code  <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            out_valid <= pub;
            if (accept) cls_q <= cls_in;
            // Unmatched values publish class 3 but leave the last code in place.
            if (pub) begin
                out_class <= cls_q;
                if (state != DEF) out_code <= W'(cls_code(cls_q));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hits <= '0;
        else if (clr_cnt) hits <= '0;
        else if (accept && hits[cls_in] != '1) hits[cls_in] <= hits[cls_in] + CNT_W'(1);
    end

endmodule

// File: tb/tb_casez_dispatch.sv
// Scoreboard bench for casez_dispatch; a second instance with CNT_W=2 covers saturation.
module tb_casez_dispatch;

    logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, clr_cnt = 1'b0;
    logic [3:0] in_value = 4'd0;
    logic       in_ready, out_valid, busy, s_in_ready, s_out_valid, s_busy;
    logic [1:0] out_class, s_out_class;
    logic [3:0] out_code, s_out_code;
    logic [31:0] hit_cnt;
    logic [7:0]  s_hit_cnt;

    int total = 0, bad = 0;
    logic [5:0] sb[$];
    logic [3:0] last_code = 4'd0;
    int exp_hit[4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    casez_dispatch dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
        .out_valid(out_valid), .out_class(out_class), .out_code(out_code), .busy(busy),
        .clr_cnt(clr_cnt), .hit_cnt(hit_cnt));

    casez_dispatch #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_value(in_value),
        .out_valid(s_out_valid), .out_class(s_out_class), .out_code(s_out_code), .busy(s_busy),
        .clr_cnt(clr_cnt), .hit_cnt(s_hit_cnt));

    function automatic logic [1:0] mdl_cls(input logic [3:0] v);
        casez (v)
            4'b0000: return 2'd0;
            4'b00?1: return 2'd1;
            4'b0100: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic void push_exp(input logic [3:0] v);
        logic [1:0] c;
        c = mdl_cls(v);
        if (c != 2'd3) last_code = {2'b00, c};
        sb.push_back({c, last_code});
        exp_hit[c]++;
    endfunction

    function automatic void clear_hits();
        for (int i = 0; i < 4; i++) exp_hit[i] = 0;
    endfunction

    // Result monitor: every out_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got class=%0d code=%b want no pulse", out_class, out_code);
            end else begin
                logic [5:0] e;
                e = sb.pop_front();
                if ({out_class, out_code} !== e) begin
                    bad++;
                    $display("FAIL sb_result got class=%0d code=%b want class=%0d code=%b",
                             out_class, out_code, e[5:4], e[3:0]);
                end
            end
        end
    end

    task automatic run_one(input logic [3:0] v, input int exp_ov, input int exp_rdy, input string nm);
        int ov_at, rdy_at;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_pre got %b want 1", nm, in_ready); end
        in_valid = 1'b1; in_value = v; push_exp(v);
        @(posedge clk); #1;
        in_valid = 1'b0; in_value = 4'($urandom);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy got %b want 1", nm, busy); end
        ov_at = -1; rdy_at = -1;
        for (int n = 1; n <= 40 && rdy_at < 0; n++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1 && ov_at < 0) ov_at = n;
            if (in_ready === 1'b1) rdy_at = n;
        end
        total += 2;
        if (ov_at != exp_ov) begin bad++; $display("FAIL %s_ov_lat got %0d want %0d", nm, ov_at, exp_ov); end
        if (rdy_at != exp_rdy) begin bad++; $display("FAIL %s_rdy_lat got %0d want %0d", nm, rdy_at, exp_rdy); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total += 3;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_ctl got ov=%b busy=%b want 0 0", out_valid, busy); end
        if (out_code !== 4'd0 || out_class !== 2'd0) begin bad++; $display("FAIL rst_out got class=%0d code=%b want 0 0000", out_class, out_code); end
        if (hit_cnt !== 32'd0) begin bad++; $display("FAIL rst_hits got %h want 0", hit_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", in_ready); end
    endtask

    task automatic test_p0();
        run_one(4'b0000, 3, 6, "p0");
        total += 2;
        if (hit_cnt[7:0] !== 8'(exp_hit[0])) begin bad++; $display("FAIL p0_hits got %0d want %0d", hit_cnt[7:0], exp_hit[0]); end
        if (out_code !== 4'b0000) begin bad++; $display("FAIL p0_code got %b want 0000", out_code); end
    endtask

    task automatic test_p1_dontcare();
        run_one(4'b0011, 3, 6, "p1a");
        run_one(4'b0001, 3, 6, "p1b");
        total++;
        if (hit_cnt[15:8] !== 8'd2) begin bad++; $display("FAIL p1_hits got %0d want 2", hit_cnt[15:8]); end
    endtask

    task automatic test_p2_default();
        run_one(4'b0100, 3, 6, "p2");
        run_one(4'b1111, 2, 2, "def");
        total += 3;
        if (out_code !== 4'b0010) begin bad++; $display("FAIL def_code got %b want 0010", out_code); end
        if (hit_cnt[23:16] !== 8'd1) begin bad++; $display("FAIL p2_hits got %0d want 1", hit_cnt[23:16]); end
        if (hit_cnt[31:24] !== 8'd1) begin bad++; $display("FAIL def_hits got %0d want 1", hit_cnt[31:24]); end
    endtask

    // in_valid held high; only values present while idle are captured.
    task automatic test_back_to_back();
        logic [3:0] vals[11] = '{4'b0100, 4'b0000, 4'b0001, 4'b0011, 4'b0000, 4'b0001, 4'b0000,
                                 4'b1000, 4'b0000, 4'b0001, 4'b0011};
        logic       rdy[11]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_value = vals[i];
            total++;
            if (in_ready !== rdy[i]) begin bad++; $display("FAIL b2b_ready[%0d] got %b want %b", i, in_ready, rdy[i]); end
            if (rdy[i]) push_exp(vals[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int n = 0; n < 40 && !(in_ready === 1'b1 && sb.size() == 0); n++) @(negedge clk);
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL b2b_drain got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        in_valid = 1'b1; in_value = 4'b0000; push_exp(4'b0000);
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        void'(sb.pop_back());
        last_code = 4'd0; clear_hits();
        #1;
        total += 3;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL abort_ctl got rdy=%b busy=%b ov=%b want 1 0 0", in_ready, busy, out_valid);
        end
        if (out_code !== 4'd0 || out_class !== 2'd0) begin bad++; $display("FAIL abort_out got class=%0d code=%b want 0 0000", out_class, out_code); end
        if (hit_cnt !== 32'd0 || s_hit_cnt !== 8'd0) begin bad++; $display("FAIL abort_hits got %h/%h want 0", hit_cnt, s_hit_cnt); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_ov[%0d] got %b want 0", i, out_valid); end
        end
        rst_n = 1'b1;
        run_one(4'b0000, 3, 6, "abort_p0");
        total++;
        if (hit_cnt[7:0] !== 8'd1) begin bad++; $display("FAIL abort_p0_hits got %0d want 1", hit_cnt[7:0]); end
    endtask

    task automatic test_sat_clear();
        @(negedge clk); clr_cnt = 1'b1;
        @(posedge clk); #1 clr_cnt = 1'b0;
        clear_hits();
        total++;
        if (hit_cnt !== 32'd0 || s_hit_cnt !== 8'd0) begin bad++; $display("FAIL clr_only got %h/%h want 0", hit_cnt, s_hit_cnt); end
        for (int i = 0; i < 5; i++) run_one(4'b0100, 3, 6, "sat_p2");
        total += 2;
        if (hit_cnt[23:16] !== 8'(exp_hit[2])) begin bad++; $display("FAIL sat_wide got %0d want %0d", hit_cnt[23:16], exp_hit[2]); end
        if (s_hit_cnt[5:4] !== 2'(sat(exp_hit[2], 3))) begin bad++; $display("FAIL sat_narrow got %0d want %0d", s_hit_cnt[5:4], sat(exp_hit[2], 3)); end
        @(negedge clk);
        in_valid = 1'b1; in_value = 4'b0100; clr_cnt = 1'b1; push_exp(4'b0100);
        @(posedge clk); #1 in_valid = 1'b0; clr_cnt = 1'b0;
        clear_hits();
        total += 2;
        if (hit_cnt[23:16] !== 8'(exp_hit[2])) begin bad++; $display("FAIL clr_hit_wide got %0d want 0", hit_cnt[23:16]); end
        if (s_hit_cnt[5:4] !== 2'd0) begin bad++; $display("FAIL clr_hit_narrow got %0d want 0", s_hit_cnt[5:4]); end
        for (int n = 0; n < 40 && !(in_ready === 1'b1 && sb.size() == 0); n++) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_p0();
        test_p1_dontcare();
        test_p2_default();
        test_back_to_back();
        test_reset_abort();
        test_sat_clear();
        repeat (10) @(negedge clk);
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
